// File: rtl/knight_rider_ctrl.sv
// knight_rider_ctrl: LED scanner with ring, bounce and fill patterns.
// It has a prescaled step rate, a pause/hold state with manual single-step,
// and registered outputs.
// Optional build macro KR_TRAIL_EN: ring and bounce patterns also light the
// previous head position, which gives a two-LED comet.
module knight_rider_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 24
) (
  input  logic                     clk_i,
  input  logic                     sys_rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     pause_i,
  input  logic [1:0]               mode_i,
  input  logic [PRESCALE_W-1:0]    period_i,
  input  logic                     step_req_i,
  output logic                     step_ack_o,
  output logic [WIDTH-1:0]         led_o,
  output logic [$clog2(WIDTH)-1:0] pos_o,
  output logic                     dir_o,
  output logic                     busy_o,
  output logic                     wrap_o
);

  localparam int POS_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_FILL   = 2'b10;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

  logic [1:0]            state_reg;
  logic [1:0]            mode_reg;
  logic [POS_W-1:0]      pos_reg;
  logic                  dir_reg;
  logic [PRESCALE_W-1:0] presc_reg;
  logic [WIDTH-1:0]      led_reg;
  logic                  wrap_reg;
  logic                  ack_reg;
  logic                  req_prev_reg;

  logic [POS_W-1:0]      step_pos;
  logic                  step_dir;
  logic                  step_wrap;
  logic [WIDTH-1:0]      step_led;
  logic                  tick;
  logic                  req_edge;

  // The prescaler compares against the live period_i. A count that is above a
  // newly lowered period rolls over through 2^PRESCALE_W before the next tick.
  assign tick     = (presc_reg == period_i);
  assign req_edge = step_req_i & ~req_prev_reg;

  // Next head position, direction and wrap flag for one pattern step.
  always_comb begin
    step_pos  = pos_reg;
    step_dir  = dir_reg;
    step_wrap = 1'b0;
    if (mode_reg == MODE_BOUNCE) begin
      if (dir_reg) begin
        step_pos = pos_reg + 1'b1;
        if (step_pos == POS_MAX) begin
          step_dir  = 1'b0;
          step_wrap = 1'b1;
        end
      end else begin
        step_pos = pos_reg - 1'b1;
        if (step_pos == '0) begin
          step_dir  = 1'b1;
          step_wrap = 1'b1;
        end
      end
    end else begin
      // Ring, fill and the spare mode all advance modulo WIDTH.
      step_dir = 1'b1;
      if (pos_reg == POS_MAX) begin
        step_pos  = '0;
        step_wrap = 1'b1;
      end else begin
        step_pos = pos_reg + 1'b1;
      end
    end
  end

  // LED image that goes with the stepped position.
  always_comb begin
    step_led = '0;
    if (mode_reg == MODE_FILL) begin
      for (int i = 0; i < WIDTH; i++) begin
        step_led[i] = (i <= int'(step_pos));
      end
    end else begin
      step_led[step_pos] = 1'b1;
`ifdef KR_TRAIL_EN
      // The trailing LED is the position just left. On start and reset the
      // LED image is a single LED, so the first frame has no tail.
      step_led[pos_reg] = 1'b1;
`endif
    end
  end

  // Control FSM, prescaler and registered pattern outputs.
  always_ff @(posedge clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= 2'b00;
      pos_reg      <= '0;
      dir_reg      <= 1'b1;
      presc_reg    <= '0;
      led_reg      <= '0;
      wrap_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      req_prev_reg <= 1'b0;
    end else begin
      wrap_reg     <= 1'b0;
      ack_reg      <= 1'b0;
      req_prev_reg <= step_req_i;
      if (stop_i) begin
        // Stop has priority over a start in the same cycle.
        state_reg <= ST_IDLE;
        pos_reg   <= '0;
        dir_reg   <= 1'b1;
        presc_reg <= '0;
        led_reg   <= '0;
      end else if (start_i) begin
        state_reg <= ST_RUN;
        mode_reg  <= mode_i;
        pos_reg   <= '0;
        dir_reg   <= 1'b1;
        presc_reg <= '0;
        led_reg   <= WIDTH'(1);
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (pause_i) begin
              state_reg <= ST_HOLD;
            end else if (tick) begin
              presc_reg <= '0;
              pos_reg   <= step_pos;
              dir_reg   <= step_dir;
              led_reg   <= step_led;
              wrap_reg  <= step_wrap;
            end else begin
              presc_reg <= presc_reg + 1'b1;
            end
          end
          ST_HOLD: begin
            if (!pause_i) begin
              state_reg <= ST_RUN;
            end
            if (req_edge) begin
              pos_reg  <= step_pos;
              dir_reg  <= step_dir;
              led_reg  <= step_led;
              wrap_reg <= step_wrap;
              ack_reg  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign led_o      = led_reg;
  assign pos_o      = pos_reg;
  assign dir_o      = dir_reg;
  assign busy_o     = (state_reg != ST_IDLE);
  assign wrap_o     = wrap_reg;
  assign step_ack_o = ack_reg;

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// tb_knight_rider_ctrl: table vectors, directed sequences and random stimulus.
// The random stimulus is checked against a step-count model of the LED patterns.
module tb_knight_rider_ctrl;

  localparam int W  = 8;
  localparam int PW = 6;

  logic          clk_i = 1'b0;
  logic          sys_rst_i;
  logic          start_i;
  logic          stop_i;
  logic          pause_i;
  logic [1:0]    mode_i;
  logic [PW-1:0] period_i;
  logic          step_req_i;
  logic          step_ack_o;
  logic [W-1:0]  led_o;
  logic [2:0]    pos_o;
  logic          dir_o;
  logic          busy_o;
  logic          wrap_o;

  knight_rider_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk_i      (clk_i),
    .sys_rst_i  (sys_rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .pause_i    (pause_i),
    .mode_i     (mode_i),
    .period_i   (period_i),
    .step_req_i (step_req_i),
    .step_ack_o (step_ack_o),
    .led_o      (led_o),
    .pos_o      (pos_o),
    .dir_o      (dir_o),
    .busy_o     (busy_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // The model state is the number of pattern steps taken since start.
  // Position, direction, LEDs and wrap all follow from that count.
  bit m_run, m_pause, m_req_prev, m_wrap, m_ack;
  int m_n, m_mode, m_count;

  function automatic int mpos(input int mode, input int n);
    int p;
    if (mode == 1) begin
      p = n % (2 * W - 2);
      return (p < W) ? p : (2 * W - 2 - p);
    end
    return n % W;
  endfunction

  function automatic int mdir(input int mode, input int n);
    if (mode == 1) return ((n % (2 * W - 2)) < (W - 1)) ? 1 : 0;
    return 1;
  endfunction

  function automatic int mwrap(input int mode, input int n);
    int p;
    if (mode == 1) begin
      p = n % (2 * W - 2);
      return (p == 0 || p == W - 1) ? 1 : 0;
    end
    return (n % W == 0) ? 1 : 0;
  endfunction

  function automatic int mled(input int mode, input int n);
    logic [W-1:0] v;
    int p;
    v = '0;
    p = mpos(mode, n);
    if (mode == 2) begin
      for (int i = 0; i <= p; i++) v[i] = 1'b1;
    end else begin
      v[p] = 1'b1;
`ifdef KR_TRAIL_EN
      if (n > 0) v[mpos(mode, n - 1)] = 1'b1;
`endif
    end
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_req_prev = 0; m_wrap = 0; m_ack = 0;
    m_n = 0; m_mode = 0; m_count = 0;
  endtask

  task automatic model_do_step();
    m_n++;
    m_wrap = mwrap(m_mode, m_n) != 0;
  endtask

  // Advance the model by one clock edge, using the inputs presented to the DUT.
  task automatic model_step();
    if (sys_rst_i) begin
      model_reset();
    end else begin
      m_wrap = 0;
      m_ack  = 0;
      if (stop_i) begin
        m_run = 0; m_pause = 0; m_n = 0; m_count = 0;
      end else if (start_i) begin
        m_run = 1; m_pause = 0; m_n = 0; m_count = 0; m_mode = int'(mode_i);
      end else if (m_run && !m_pause) begin
        if (pause_i) m_pause = 1;
        else if (m_count == int'(period_i)) begin
          m_count = 0;
          model_do_step();
        end else m_count = (m_count + 1) % (1 << PW);
      end else if (m_run && m_pause) begin
        if (!pause_i) m_pause = 0;
        if (step_req_i && !m_req_prev) begin
          model_do_step();
          m_ack = 1;
        end
      end
      m_req_prev = step_req_i;
    end
  endtask

  task automatic compare_model();
    check("m_led",  int'(led_o),      m_run ? mled(m_mode, m_n) : 0);
    check("m_pos",  int'(pos_o),      m_run ? mpos(m_mode, m_n) : 0);
    check("m_dir",  int'(dir_o),      m_run ? mdir(m_mode, m_n) : 1);
    check("m_busy", int'(busy_o),     int'(m_run));
    check("m_wrap", int'(wrap_o),     int'(m_wrap));
    check("m_ack",  int'(step_ack_o), int'(m_ack));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic set_idle();
    start_i = 0; stop_i = 0; pause_i = 0; step_req_i = 0;
  endtask

  typedef struct {
    logic       start, stop, pause;
    logic [1:0] mode;
    logic [5:0] period;
    logic       req;
    logic [7:0] led, led_trail;
    int         pos;
    logic       dir, busy, wrap, ack;
  } vec_t;

  vec_t vecs[14];
  int   wraps, acks, p;

  initial begin
    // start stop pause mode period req | led ledT pos dir busy wrap ack
    vecs[0]  = '{0,0,0,2'd0,6'd0,0, 8'h00,8'h00, 0,1,0,0,0};
    vecs[1]  = '{1,0,0,2'd1,6'd0,0, 8'h01,8'h01, 0,1,1,0,0};
    vecs[2]  = '{0,0,0,2'd1,6'd0,0, 8'h02,8'h03, 1,1,1,0,0};
    vecs[3]  = '{0,0,0,2'd1,6'd0,0, 8'h04,8'h06, 2,1,1,0,0};
    vecs[4]  = '{0,0,1,2'd1,6'd0,0, 8'h04,8'h06, 2,1,1,0,0};
    vecs[5]  = '{0,0,1,2'd1,6'd0,1, 8'h08,8'h0C, 3,1,1,0,1};
    vecs[6]  = '{0,0,1,2'd1,6'd0,1, 8'h08,8'h0C, 3,1,1,0,0};
    vecs[7]  = '{0,0,0,2'd1,6'd0,0, 8'h08,8'h0C, 3,1,1,0,0};
    vecs[8]  = '{0,0,0,2'd1,6'd0,0, 8'h10,8'h18, 4,1,1,0,0};
    vecs[9]  = '{0,0,0,2'd1,6'd0,1, 8'h20,8'h30, 5,1,1,0,0};
    vecs[10] = '{1,1,0,2'd1,6'd0,0, 8'h00,8'h00, 0,1,0,0,0};
    vecs[11] = '{1,0,0,2'd2,6'd0,0, 8'h01,8'h01, 0,1,1,0,0};
    vecs[12] = '{0,0,0,2'd0,6'd0,0, 8'h03,8'h03, 1,1,1,0,0};
    vecs[13] = '{0,1,0,2'd0,6'd0,0, 8'h00,8'h00, 0,1,0,0,0};

    sys_rst_i = 1; set_idle(); mode_i = 0; period_i = 0;
    model_reset();
    @(posedge clk_i); #1;
    check("rst_led",  int'(led_o), 0);
    check("rst_pos",  int'(pos_o), 0);
    check("rst_dir",  int'(dir_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_wrap", int'(wrap_o), 0);
    check("rst_ack",  int'(step_ack_o), 0);
    cycle();
    sys_rst_i = 0;
    cycle();

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      start_i = vecs[i].start; stop_i = vecs[i].stop; pause_i = vecs[i].pause;
      mode_i = vecs[i].mode; period_i = vecs[i].period; step_req_i = vecs[i].req;
      cycle();
`ifdef KR_TRAIL_EN
      check("tbl_led", int'(led_o), int'(vecs[i].led_trail));
`else
      check("tbl_led", int'(led_o), int'(vecs[i].led));
`endif
      check("tbl_pos",  int'(pos_o), vecs[i].pos);
      check("tbl_dir",  int'(dir_o), int'(vecs[i].dir));
      check("tbl_busy", int'(busy_o), int'(vecs[i].busy));
      check("tbl_wrap", int'(wrap_o), int'(vecs[i].wrap));
      check("tbl_ack",  int'(step_ack_o), int'(vecs[i].ack));
      $display("vec %0d: led=%02h pos=%0d dir=%0d busy=%0d ack=%0d", i, led_o, pos_o, dir_o, busy_o, step_ack_o);
    end
    set_idle();

    // Ring, period 3: one step every 4 clocks, a wrap every 32 clocks.
    start_i = 1; mode_i = 2'b00; period_i = 3; cycle(); start_i = 0;
    wraps = 0;
    for (int k = 1; k <= 64; k++) begin
      cycle();
      check("ring_led", int'(led_o), mled(0, k / 4));
      if (wrap_o) wraps++;
    end
    check("ring_wraps", wraps, 2);
    $display("ring period 3: wraps=%0d over 64 clocks", wraps);

    // Bounce, period 0: 14-step cycle with a wrap at each end.
    start_i = 1; mode_i = 2'b01; period_i = 0; cycle(); start_i = 0;
    for (int k = 1; k <= 28; k++) begin
      cycle();
      p = k % 14;
      check("bnc_pos",  int'(pos_o), (p < 8) ? p : 14 - p);
      check("bnc_dir",  int'(dir_o), (p < 7) ? 1 : 0);
      check("bnc_wrap", int'(wrap_o), (p == 0 || p == 7) ? 1 : 0);
    end
    $display("bounce period 0: pos=%0d dir=%0d after 28 steps", pos_o, dir_o);

    // Fill, period 0: 01,03..FF,01 with a wrap on the FF to 01 step.
    start_i = 1; mode_i = 2'b10; cycle(); start_i = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      check("fill_led",  int'(led_o), (1 << ((k % 8) + 1)) - 1);
      check("fill_wrap", int'(wrap_o), (k % 8 == 0) ? 1 : 0);
    end
    $display("fill period 0: led=%02h after 16 steps", led_o);

    // Pause at pos 2, then two short step requests and one held for 5 clocks.
    start_i = 1; mode_i = 2'b00; period_i = 0; cycle(); start_i = 0;
    cycle(); cycle();
    check("hold_pos_pre", int'(pos_o), 2);
    pause_i = 1; cycle();
    acks = 0;
    for (int r = 0; r < 11; r++) begin
      step_req_i = (r == 0 || r == 2 || (r >= 4 && r <= 8));
      cycle();
      if (step_ack_o) acks++;
    end
    step_req_i = 0;
    check("hold_pos", int'(pos_o), 5);
    check("hold_acks", acks, 3);
    $display("hold: pos=%0d acks=%0d", pos_o, acks);
    set_idle();

    // Asynchronous reset mid-run: outputs clear before the next clock edge.
    start_i = 1; mode_i = 2'b01; period_i = 0; cycle(); start_i = 0;
    for (int k = 0; k < 5; k++) cycle();
    @(posedge clk_i);
    model_step();
    #3 sys_rst_i = 1;
    #1;
    check("arst_led",  int'(led_o), 0);
    check("arst_pos",  int'(pos_o), 0);
    check("arst_dir",  int'(dir_o), 1);
    check("arst_busy", int'(busy_o), 0);
    check("arst_wrap", int'(wrap_o), 0);
    model_reset();
    cycle(); cycle();
    sys_rst_i = 0;
    for (int k = 0; k < 5; k++) cycle();
    check("arst_idle", int'(busy_o), 0);
    $display("async reset: busy=%0d led=%02h", busy_o, led_o);

    // Lowering the period below the count: the count rolls over at 2^PW, no early tick.
    start_i = 1; mode_i = 2'b00; period_i = 40; cycle(); start_i = 0;
    for (int k = 0; k < 20; k++) cycle();
    period_i = 5;
    for (int k = 0; k < 49; k++) cycle();
    check("pwrap_pos_before", int'(pos_o), 0);
    cycle();
    check("pwrap_pos_after", int'(pos_o), 1);
    $display("period lowered: pos=%0d after rollover", pos_o);
    set_idle();

    // Random stimulus against the model.
    period_i = 0;
    for (int c = 0; c < 3000; c++) begin
      start_i    = ($urandom_range(0, 99) < 3);
      stop_i     = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 19) == 0) pause_i = ~pause_i;
      step_req_i = ($urandom_range(0, 2) == 0);
      mode_i     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) period_i = PW'($urandom_range(0, 4));
      cycle();
    end
    $display("random: 3000 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
